// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run-control and interlock logic.
package pipe_ctrl_pkg;

  localparam int unsigned NREG   = 8;
  localparam int unsigned RA_W   = 3;
  localparam int unsigned INSN_W = 16;

  // Instruction word loaded into ID_EX when a bubble is injected
  localparam logic [INSN_W-1:0] NOP_INSN = 16'h0000;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } run_state_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register count of in-flight writes: issued at ID->EX, retired at WB.
module pipe_scoreboard #(
  parameter int unsigned NREG      = 8,
  parameter int unsigned RA_W      = 3,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_wr_i,
  input  logic [RA_W-1:0] issue_addr_i,
  input  logic            wb_wr_en_i,
  input  logic [RA_W-1:0] wb_addr_i,
  input  logic [RA_W-1:0] rd1_addr_i,
  input  logic [RA_W-1:0] rd2_addr_i,
  output logic            rd1_ready_o,
  output logic            rd2_ready_o,
  output logic            wr_full_o,
  output logic            sb_err_o
);
  import pipe_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  retire, ready, inc, dec;
  logic             err_q, err_d;

  always_comb begin
    err_d = err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      retire[r] = wb_wr_en_i && (wb_addr_i == RA_W'(r));
      // With write-before-read the last outstanding write lands in time for ID
      ready[r]  = (cnt_q[r] == '0) || (WB_BYPASS && retire[r] && (cnt_q[r] == CntOne));
      inc[r]    = issue_wr_i && (issue_addr_i == RA_W'(r));
      dec[r]    = retire[r] && (cnt_q[r] != '0);
      cnt_d[r]  = cnt_q[r];
      if (inc[r] && !dec[r] && (cnt_q[r] != CntMax)) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec[r] && !inc[r]) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
      if (retire[r] && (cnt_q[r] == '0)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rd1_ready_o = ready[rd1_addr_i];
  assign rd2_ready_o = ready[rd2_addr_i];
  assign wr_full_o   = (cnt_q[issue_addr_i] == CntMax);
  assign sb_err_o    = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW interlock plus RUN/HALT/STEP debug control for the 5-stage pipeline front end.
module pipe_hazard_ctrl #(
  parameter int unsigned NREG      = pipe_ctrl_pkg::NREG,
  parameter int unsigned RA_W      = pipe_ctrl_pkg::RA_W,
  parameter int unsigned CNT_W     = 2,
  parameter bit          WB_BYPASS = 1'b1,
  parameter bit          START_RUN = 1'b1,
  parameter int unsigned STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_req,
  input  logic               halt_req,
  input  logic               step_req,
  input  logic               id_valid,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic [RA_W-1:0]    id_read1_addr,
  input  logic [RA_W-1:0]    id_read2_addr,
  input  logic               id_wr_en,
  input  logic [RA_W-1:0]    id_write_addr,
  input  logic               wb_wr_en,
  input  logic [RA_W-1:0]    wb_write_addr,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               id_ex_bubble,
  output logic               issue,
  output logic [1:0]         state,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               sb_err
);
  import pipe_ctrl_pkg::*;

  run_state_e         state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               rd1_ready, rd2_ready, wr_full;
  logic               hazard, permit, adv;

  pipe_scoreboard #(
    .NREG      (NREG),
    .RA_W      (RA_W),
    .CNT_W     (CNT_W),
    .WB_BYPASS (WB_BYPASS)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (rst),
    .issue_wr_i   (issue & id_wr_en),
    .issue_addr_i (id_write_addr),
    .wb_wr_en_i   (wb_wr_en),
    .wb_addr_i    (wb_write_addr),
    .rd1_addr_i   (id_read1_addr),
    .rd2_addr_i   (id_read2_addr),
    .rd1_ready_o  (rd1_ready),
    .rd2_ready_o  (rd2_ready),
    .wr_full_o    (wr_full),
    .sb_err_o     (sb_err)
  );

  assign hazard = id_valid & ((id_use1 & ~rd1_ready) | (id_use2 & ~rd2_ready) |
                              (id_wr_en & wr_full));
  assign permit = (state_q != StHalt);
  assign adv    = permit & ~hazard;

  assign pc_en        = adv;
  assign if_id_en     = adv;
  assign id_ex_bubble = ~adv | ~id_valid;
  assign issue        = adv & id_valid;
  assign state        = state_q;
  assign stall_cnt    = stall_q;

  always_comb begin
    state_d = state_q;
    if (halt_req) begin
      state_d = StHalt;
    end else begin
      case (state_q)
        StHalt: begin
          if (step_req) begin
            state_d = StStep;
          end else if (run_req) begin
            state_d = StRun;
          end
        end
        // Leave STEP only once a real instruction has gone through
        StStep:  if (issue) state_d = StHalt;
        StRun:   state_d = StRun;
        default: state_d = StHalt;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (permit && hazard && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= START_RUN ? StRun : StHalt;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a scoreboard model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run_req, halt_req, step_req;
  logic        id_valid, id_use1, id_use2, id_wr_en, wb_wr_en;
  logic [2:0]  id_read1_addr, id_read2_addr, id_write_addr, wb_write_addr;
  logic        pc_en, if_id_en, id_ex_bubble, issue, sb_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic        pc_en_nb, if_id_en_nb, id_ex_bubble_nb, issue_nb, sb_err_nb;
  logic [1:0]  state_nb;
  logic [15:0] stall_cnt_nb;

  pipe_hazard_ctrl #(
    .NREG(8), .RA_W(3), .CNT_W(2), .WB_BYPASS(1'b1), .START_RUN(1'b1), .STALL_W(16)
  ) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
    .id_read1_addr(id_read1_addr), .id_read2_addr(id_read2_addr),
    .id_wr_en(id_wr_en), .id_write_addr(id_write_addr),
    .wb_wr_en(wb_wr_en), .wb_write_addr(wb_write_addr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble), .issue(issue),
    .state(state), .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  pipe_hazard_ctrl #(
    .NREG(8), .RA_W(3), .CNT_W(2), .WB_BYPASS(1'b0), .START_RUN(1'b1), .STALL_W(16)
  ) dut_nb (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .id_valid(id_valid), .id_use1(id_use1), .id_use2(id_use2),
    .id_read1_addr(id_read1_addr), .id_read2_addr(id_read2_addr),
    .id_wr_en(id_wr_en), .id_write_addr(id_write_addr),
    .wb_wr_en(wb_wr_en), .wb_write_addr(wb_write_addr),
    .pc_en(pc_en_nb), .if_id_en(if_id_en_nb), .id_ex_bubble(id_ex_bubble_nb),
    .issue(issue_nb), .state(state_nb), .stall_cnt(stall_cnt_nb), .sb_err(sb_err_nb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the bypass instance: outstanding writes per register, run mode, stats
  int m_cnt [8];
  int m_state;   // 0 halted, 1 running, 2 stepping
  int m_stall;
  bit m_err;

  function automatic bit m_ready(int r);
    if (m_cnt[r] == 0) return 1'b1;
    return wb_wr_en && (int'(wb_write_addr) == r) && (m_cnt[r] == 1);
  endfunction

  function automatic bit m_hazard();
    if (!id_valid) return 1'b0;
    if (id_use1 && !m_ready(int'(id_read1_addr))) return 1'b1;
    if (id_use2 && !m_ready(int'(id_read2_addr))) return 1'b1;
    if (id_wr_en && m_cnt[int'(id_write_addr)] == 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_adv();
    return (m_state != 0) && !m_hazard();
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_state = 1;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  // Advance one clock; the model commits from the inputs held across the edge
  task automatic tick();
    bit h, iss, ret, inc, dec;
    h   = m_hazard();
    iss = m_adv() && id_valid;
    @(posedge clk);
    if (rst === 1'b0) begin
      model_reset();
    end else begin
      for (int r = 0; r < 8; r++) begin
        ret = wb_wr_en && (int'(wb_write_addr) == r);
        inc = iss && id_wr_en && (int'(id_write_addr) == r);
        dec = ret && (m_cnt[r] > 0);
        if (ret && m_cnt[r] == 0) m_err = 1'b1;
        m_cnt[r] = m_cnt[r] + int'(inc) - int'(dec);
      end
      if (m_state != 0 && h && m_stall < 65535) m_stall++;
      if (halt_req) m_state = 0;
      else if (m_state == 0 && step_req) m_state = 2;
      else if (m_state == 0 && run_req) m_state = 1;
      else if (m_state == 2 && iss) m_state = 0;
    end
    #1;
  endtask

  task automatic set_id(bit v, bit u1, int r1, bit u2, int r2, bit w, int wa);
    id_valid = v; id_use1 = u1; id_read1_addr = 3'(r1);
    id_use2 = u2; id_read2_addr = 3'(r2); id_wr_en = w; id_write_addr = 3'(wa);
  endtask

  task automatic set_wb(bit en, int a);
    wb_wr_en = en; wb_write_addr = 3'(a);
  endtask

  task automatic do_reset();
    run_req = 0; halt_req = 0; step_req = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL reset_state: got %0d want 1", state); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err: got %0d want 0", sb_err); end
    n_tests++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL reset_pc_en: got %0d want 1", pc_en); end
    n_tests++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %0d want 1", id_ex_bubble); end
    n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL reset_issue: got %0d want 0", issue); end
    tick();
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_id(1, 1, 0, 1, 7, 1, 1 + i % 3);
      #2;
      n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL indep_issue[%0d]: got %0d want 1", i, issue); end
      n_tests++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL indep_pc_en[%0d]: got %0d want 1", i, pc_en); end
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    #2;
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL indep_stall: got %0d want 0", stall_cnt); end
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL indep_state: got %0d want 1", state); end
    tick();
  endtask

  task automatic test_raw_dep();
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 3);
    #2;
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL raw_producer: got %0d want 1", issue); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      set_id(1, 1, 3, 0, 0, 1, 4);
      set_wb(c == 3, 3);
      #2;
      if (c <= 2) begin
        n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL raw_stall_pc[%0d]: got %0d want 0", c, pc_en); end
        n_tests++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL raw_stall_bubble[%0d]: got %0d want 1", c, id_ex_bubble); end
      end
      if (c == 3) begin
        n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_issue: got %0d want 1", issue); end
        n_tests++; if (issue_nb !== 1'b0) begin n_fail++; $display("FAIL raw_nobypass_hold: got %0d want 0", issue_nb); end
      end
      if (c == 4) begin
        n_tests++; if (issue_nb !== 1'b1) begin n_fail++; $display("FAIL raw_nobypass_issue: got %0d want 1", issue_nb); end
      end
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    #2;
    n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_stall_cnt_bypass: got %0d want 2", stall_cnt); end
    n_tests++; if (stall_cnt_nb !== 16'd3) begin n_fail++; $display("FAIL raw_stall_cnt_nobypass: got %0d want 3", stall_cnt_nb); end
    tick();
  endtask

  task automatic test_saturation();
    bit want;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_id(1, 0, 0, 0, 0, 1, 5);
      set_wb(i == 6, 5);
      want = (i < 3) || (i == 7);
      #2;
      n_tests++; if (issue !== want) begin n_fail++; $display("FAIL sat_issue[%0d]: got %0d want %0d", i, issue, want); end
      n_tests++; if (id_ex_bubble !== !want) begin n_fail++; $display("FAIL sat_bubble[%0d]: got %0d want %0d", i, id_ex_bubble, !want); end
      tick();
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    #2;
    n_tests++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d want 5", stall_cnt); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 2);
    #2; tick();
    set_wb(1, 2);
    #2;
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL sim_issue_retire: got %0d want 1", issue); end
    tick();
    set_id(1, 1, 2, 0, 0, 0, 0);
    set_wb(0, 0);
    #2;
    n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL sim_cnt_nonzero: got %0d want 0", pc_en); end
    tick();
    set_wb(1, 2);
    #2;
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL sim_cnt_one: got %0d want 1", issue); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 6);
    #2;
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sim_err_before: got %0d want 0", sb_err); end
    tick();
    set_wb(0, 0);
    #2;
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sim_err_set: got %0d want 1", sb_err); end
    tick(); tick();
    #2;
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL sim_err_sticky: got %0d want 1", sb_err); end
    rst = 1'b0; tick(); rst = 1'b1;
    #2;
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sim_err_clear: got %0d want 0", sb_err); end
    tick();
  endtask

  task automatic test_step();
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 3);
    halt_req = 1;
    #2;
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL step_last_run_issue: got %0d want 1", issue); end
    tick();
    halt_req = 0;
    set_id(1, 1, 3, 0, 0, 1, 4);
    step_req = 1;
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_halted: got %0d want 0", state); end
    n_tests++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL step_halt_pc: got %0d want 0", pc_en); end
    tick();
    step_req = 0;
    #2;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL step_entered: got %0d want 2", state); end
    n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL step_hazard_hold: got %0d want 0", issue); end
    tick();
    set_wb(1, 3);
    #2;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL step_still_step: got %0d want 2", state); end
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL step_issue_once: got %0d want 1", issue); end
    tick();
    set_wb(0, 0);
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_back_halt: got %0d want 0", state); end
    n_tests++; if (issue !== 1'b0) begin n_fail++; $display("FAIL step_no_second: got %0d want 0", issue); end
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL step_stall_cnt: got %0d want 1", stall_cnt); end
    set_id(1, 0, 0, 0, 0, 0, 0);
    step_req = 1;
    tick();
    step_req = 0;
    #2;
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL step_free_issue: got %0d want 1", issue); end
    tick();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_free_halt: got %0d want 0", state); end
    halt_req = 1; run_req = 1;
    tick();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_halt_prio_h: got %0d want 0", state); end
    halt_req = 0;
    tick();
    #2;
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL step_run: got %0d want 1", state); end
    halt_req = 1;
    tick();
    #2;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_halt_prio_r: got %0d want 0", state); end
    halt_req = 0; run_req = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 4);
    tick(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    halt_req = 1;
    tick();
    halt_req = 0;
    set_id(1, 1, 4, 0, 0, 0, 0);
    step_req = 1;
    tick();
    step_req = 0;
    #2;
    n_tests++; if (state !== 2'd2) begin n_fail++; $display("FAIL mid_in_step: got %0d want 2", state); end
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL mid_state: got %0d want 1", state); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_stall: got %0d want 0", stall_cnt); end
    n_tests++; if (issue !== 1'b1) begin n_fail++; $display("FAIL mid_counts_clear: got %0d want 1", issue); end
    tick();
  endtask

  task automatic test_random();
    bit e_adv;
    int s, pick;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) != 0);
      halt_req = ($urandom_range(0, 19) == 0);
      run_req  = ($urandom_range(0, 9) == 0);
      step_req = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2) != 0,
             $urandom_range(0, 7));
      pick = -1;
      if ($urandom_range(0, 9) < 5) begin
        s = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) if (pick < 0 && m_cnt[(s + k) % 8] > 0) pick = (s + k) % 8;
        if (pick < 0 && $urandom_range(0, 9) == 0) pick = s;
      end
      set_wb(pick >= 0, (pick >= 0) ? pick : 0);
      #2;
      e_adv = m_adv();
      n_tests++; if (pc_en !== e_adv) begin n_fail++; $display("FAIL rnd_pc_en[%0d]: got %0d want %0d", i, pc_en, e_adv); end
      n_tests++; if (if_id_en !== e_adv) begin n_fail++; $display("FAIL rnd_if_id_en[%0d]: got %0d want %0d", i, if_id_en, e_adv); end
      n_tests++; if (id_ex_bubble !== (!e_adv || !id_valid)) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %0d want %0d", i, id_ex_bubble, !e_adv || !id_valid); end
      n_tests++; if (issue !== (e_adv && id_valid)) begin n_fail++; $display("FAIL rnd_issue[%0d]: got %0d want %0d", i, issue, e_adv && id_valid); end
      n_tests++; if (int'(state) !== m_state) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_state); end
      n_tests++; if (int'(stall_cnt) !== m_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_cnt, m_stall); end
      n_tests++; if (sb_err !== m_err) begin n_fail++; $display("FAIL rnd_sb_err[%0d]: got %0d want %0d", i, sb_err, m_err); end
      tick();
    end
    rst = 1'b1; halt_req = 0; run_req = 0; step_req = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    test_reset();
    test_independent();
    test_raw_dep();
    test_saturation();
    test_simultaneous();
    test_step();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
